clock_display_driver: RTL and testbench
=======================================

Name: clock_display_driver

Overview:
- Reads the time/mode outputs of the 12-hour clock core and drives a 6-digit, active-low, multiplexed seven-segment display as HH.MM.SS.
- Takes a tear-free snapshot of the inputs once per scan frame and converts each field to BCD.
- Suppresses the hour leading zero, shows dashes for out-of-range fields, and blinks the display while the core is in edit mode.
- Sits between the clock core and the board display pins.

Parameters:
CLK_FRQ, 100000000, input clock frequency in Hz
REFRESH_HZ, 1000, digit-advance rate in Hz; DIGIT_TICKS = CLK_FRQ/REFRESH_HZ (must be >= 2)
BLINK_HZ, 2, edit-mode blink rate in Hz; BLINK_TICKS = CLK_FRQ/(2*BLINK_HZ) cycles per blink half-period

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
second  input  6  binary seconds from clock core
minute  input  6  binary minutes from clock core
hour  input  5  binary hours from clock core
idle_mode  input  1  core is in idle state
run_mode  input  1  core is in run state
edit_mode  input  1  core is in edit state
an  output  8  digit anodes, active-low; an[7:6] held high permanently
seg  output  7  segments, active-low; seg[0]=a ... seg[6]=g
dp  output  1  decimal point, active-low
frame_start  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset (async): an=8'hFF, seg=7'h7F, dp=1, frame_start=0; digit_cnt=0, digit_idx=0, blink_cnt=0, blink_on=1, snapshot registers=0.
- Digit timer: digit_cnt runs 0..DIGIT_TICKS-1. At DIGIT_TICKS-1 it wraps to 0 and digit_idx advances 0..5, with 5 wrapping to 0.
- Digit map:
  - idx0 = sec ones, idx1 = sec tens
  - idx2 = min ones, idx3 = min tens
  - idx4 = hour ones, idx5 = hour tens
  - an bit n is driven low for idx n.
- Snapshot:
  - On the cycle digit_idx wraps 5->0, latch second, minute, hour, edit_mode, idle_mode into snapshot registers and pulse frame_start for 1 cycle.
  - Input changes mid-frame are invisible until the next wrap.
  - The first snapshot occurs at the first 5->0 wrap after reset; until then the display shows all-zero snapshot values.
- BCD conversion, combinational from the snapshot registers:
  - tens = v/10, ones = v%10.
  - sec or min > 59 -> both digits of that field show dash (seg=7'b0111111).
  - hour > 12 -> both hour digits show dash.
  - hour tens digit = 0 with a valid hour -> blank (seg=7'h7F, anode still driven). Hour 0 therefore displays " 0".
- Segment codes (active-low g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Output registering and anti-ghosting:
  - an/seg/dp are registered.
  - On a cycle where digit_cnt==0, an=8'hFF (all digits off) and seg/dp load the pattern for the current digit_idx.
  - For digit_cnt 1..DIGIT_TICKS-1, an drives the current digit.
- Decimal point: dp=0 on idx2 and idx4 when the snapshot idle_mode=0; otherwise dp=1.
- Blink:
  - While the live edit_mode=0: blink_cnt=0, blink_on=1.
  - While edit_mode=1: blink_cnt counts 0..BLINK_TICKS-1 and blink_on toggles at wrap.
  - With snapshot edit_mode=1 and blink_on=0: seg=7'h7F on all digits. an scanning and dp are unaffected.
- Modes: run and idle use identical digit content; only dp differs. Simultaneous mode flags are not arbitrated; only edit_mode and idle_mode are consulted.
- Reset mid-scan: outputs return to reset values immediately. Scanning restarts at idx0 on the first clk edge after rst falls.

Test Plan:
(Parameters for all benches: CLK_FRQ=1200, REFRESH_HZ=100 -> DIGIT_TICKS=12; BLINK_HZ=10 -> BLINK_TICKS=60. One frame = 72 cycles.)
1. Reset check: assert rst -> an=FF, seg=7F, dp=1, frame_start=0; release rst -> an=FF during cycle digit_cnt==0, then an=FE.
2. Digit content: second=37, minute=5, hour=12, run_mode=1, one frame after snapshot ->
   - idx0 seg=1111000, an=FE; idx1 seg=0110000, an=FD
   - idx2 seg=0010010, dp=0; idx3 seg=1000000
   - idx4 seg=0100100, dp=0; idx5 seg=1111001, an=DF
   - an[7:6]=11 throughout.
3. Hour leading zero and dashes: hour=7, minute=60 -> idx5 seg=7F with an=DF; idx4 seg=1111000; idx2 and idx3 seg=0111111.
4. Tear-free snapshot: change second 37->38 during idx3 -> idx0/idx1 keep showing 37 until after the next frame_start, then show 38.
5. Edit blink: edit_mode=1 held -> digits normal for 60 cycles, seg=7F on all digits for the next 60, repeating; dp still low on idx2 and idx4.
6. Async reset mid-scan during idx3: an=FF, seg=7F in the same cycle with no clock edge; after release, scanning resumes from idx0.

Source files
------------

// File: rtl/clock_display_driver.sv
// Six-digit multiplexed seven-segment driver for the 12-hour clock core.
// Shows HH.MM.SS from a per-frame snapshot, with dashes, hour blanking and edit blink.
`timescale 1ns/1ps
module clock_display_driver #(
  parameter int unsigned CLK_FRQ    = 100000000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned BLINK_HZ   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] second,
  input  logic [5:0] minute,
  input  logic [4:0] hour,
  input  logic       idle_mode,
  input  logic       run_mode,
  input  logic       edit_mode,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int unsigned DIGIT_TICKS = CLK_FRQ / REFRESH_HZ;
  localparam int unsigned BLINK_TICKS = CLK_FRQ / (2 * BLINK_HZ);
  localparam int unsigned CNT_W = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
  localparam int unsigned BLK_W = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  logic [CNT_W-1:0] digit_cnt_q, digit_cnt_d;
  logic [2:0]       digit_idx_q, digit_idx_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic [5:0]       snap_sec_q, snap_sec_d;
  logic [5:0]       snap_min_q, snap_min_d;
  logic [4:0]       snap_hour_q, snap_hour_d;
  logic             snap_edit_q, snap_edit_d;
  logic             snap_idle_q, snap_idle_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_start_q, frame_start_d;

  // run_mode carries no information the display needs
  logic unused_run;
  assign unused_run = run_mode;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1000000;
      4'd1:    seg_enc = 7'b1111001;
      4'd2:    seg_enc = 7'b0100100;
      4'd3:    seg_enc = 7'b0110000;
      4'd4:    seg_enc = 7'b0011001;
      4'd5:    seg_enc = 7'b0010010;
      4'd6:    seg_enc = 7'b0000010;
      4'd7:    seg_enc = 7'b1111000;
      4'd8:    seg_enc = 7'b0000000;
      4'd9:    seg_enc = 7'b0010000;
      default: seg_enc = 7'h7F;
    endcase
  endfunction

  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
  logic       sec_bad, min_bad, hour_bad;
  logic [6:0] pat;

  always_comb begin
    digit_cnt_d   = digit_cnt_q + CNT_W'(1);
    digit_idx_d   = digit_idx_q;
    snap_sec_d    = snap_sec_q;
    snap_min_d    = snap_min_q;
    snap_hour_d   = snap_hour_q;
    snap_edit_d   = snap_edit_q;
    snap_idle_d   = snap_idle_q;
    frame_start_d = 1'b0;
    blink_cnt_d   = blink_cnt_q;
    blink_on_d    = blink_on_q;

    // Scan timer; the 5->0 wrap is the only point where the snapshot changes
    if (digit_cnt_q == CNT_W'(DIGIT_TICKS - 1)) begin
      digit_cnt_d = '0;
      if (digit_idx_q == 3'd5) begin
        digit_idx_d   = 3'd0;
        snap_sec_d    = second;
        snap_min_d    = minute;
        snap_hour_d   = hour;
        snap_edit_d   = edit_mode;
        snap_idle_d   = idle_mode;
        frame_start_d = 1'b1;
      end else begin
        digit_idx_d = digit_idx_q + 3'd1;
      end
    end

    // Blink phase follows the live edit flag so it restarts on each edit entry
    if (!edit_mode) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLK_W'(BLINK_TICKS - 1)) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLK_W'(1);
    end

    sec_tens  = 4'(snap_sec_q / 6'd10);
    sec_ones  = 4'(snap_sec_q % 6'd10);
    min_tens  = 4'(snap_min_q / 6'd10);
    min_ones  = 4'(snap_min_q % 6'd10);
    hour_tens = 4'(snap_hour_q / 5'd10);
    hour_ones = 4'(snap_hour_q % 5'd10);
    sec_bad   = snap_sec_q > 6'd59;
    min_bad   = snap_min_q > 6'd59;
    hour_bad  = snap_hour_q > 5'd12;

    case (digit_idx_q)
      3'd0:    pat = sec_bad  ? SEG_DASH : seg_enc(sec_ones);
      3'd1:    pat = sec_bad  ? SEG_DASH : seg_enc(sec_tens);
      3'd2:    pat = min_bad  ? SEG_DASH : seg_enc(min_ones);
      3'd3:    pat = min_bad  ? SEG_DASH : seg_enc(min_tens);
      3'd4:    pat = hour_bad ? SEG_DASH : seg_enc(hour_ones);
      3'd5:    pat = hour_bad ? SEG_DASH :
                     ((hour_tens == 4'd0) ? SEG_BLANK : seg_enc(hour_tens));
      default: pat = SEG_BLANK;
    endcase
    if (snap_edit_q && !blink_on_q) pat = SEG_BLANK;

    seg_d = pat;
    dp_d  = ~(((digit_idx_q == 3'd2) || (digit_idx_q == 3'd4)) && !snap_idle_q);
    // All anodes off on the first tick of each digit to avoid ghosting
    an_d  = 8'hFF;
    if (digit_cnt_q != '0) an_d = ~(8'(1) << digit_idx_q);
    an_d[7:6] = 2'b11;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_cnt_q   <= '0;
      digit_idx_q   <= 3'd0;
      blink_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      snap_sec_q    <= 6'd0;
      snap_min_q    <= 6'd0;
      snap_hour_q   <= 5'd0;
      snap_edit_q   <= 1'b0;
      snap_idle_q   <= 1'b0;
      an_q          <= 8'hFF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      digit_cnt_q   <= digit_cnt_d;
      digit_idx_q   <= digit_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_on_q    <= blink_on_d;
      snap_sec_q    <= snap_sec_d;
      snap_min_q    <= snap_min_d;
      snap_hour_q   <= snap_hour_d;
      snap_edit_q   <= snap_edit_d;
      snap_idle_q   <= snap_idle_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed bench for clock_display_driver: 12 ticks per digit, 72-cycle frame,
// 60-cycle blink half-period.
`timescale 1ns/1ps
module tb_clock_display_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] second = 6'd37;
  logic [5:0] minute = 6'd5;
  logic [4:0] hour = 5'd12;
  logic       idle_mode = 1'b0;
  logic       run_mode = 1'b1;
  logic       edit_mode = 1'b0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int total = 0;
  int bad = 0;

  clock_display_driver #(.CLK_FRQ(1200), .REFRESH_HZ(100), .BLINK_HZ(10)) dut (
    .clk(clk), .rst(rst), .second(second), .minute(minute), .hour(hour),
    .idle_mode(idle_mode), .run_mode(run_mode), .edit_mode(edit_mode),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Returns at the falling edge where frame_start is high
  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (frame_start !== 1'b1) begin
      bad++;
      $display("FAIL frame_timeout: frame_start=%b after %0d cycles, need 1", frame_start, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: an=%h seg=%b dp=%b fs=%b, need FF 1111111 1 0", an, seg, dp, frame_start);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (an !== 8'hFF || seg !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_first: an=%h seg=%b, need FF 1000000", an, seg);
    end
    @(negedge clk);
    total++;
    if (an !== 8'hFE) begin
      bad++;
      $display("FAIL reset_second: an=%h, need FE", an);
    end
  endtask

  task automatic test_digit_content();
    logic [6:0] exp_seg [0:5];
    logic [7:0] exp_an;
    exp_seg = '{7'b1111000, 7'b0110000, 7'b0010010, 7'b1000000, 7'b0100100, 7'b1111001};
    for (int i = 0; i < 6; i++) begin
      wait_frame();
      repeat (12 * i + 6) @(negedge clk);
      exp_an = ~(8'h01 << i);
      total++;
      if (an !== exp_an || seg !== exp_seg[i] || dp !== ((i == 2 || i == 4) ? 1'b0 : 1'b1)) begin
        bad++;
        $display("FAIL content_idx%0d: an=%h seg=%b dp=%b, need %h %b %b", i, an, seg, dp,
                 exp_an, exp_seg[i], ((i == 2 || i == 4) ? 1'b0 : 1'b1));
      end
    end
  endtask

  task automatic test_dash_blank();
    logic [6:0] exp_seg [0:5];
    logic [7:0] exp_an;
    hour = 5'd7;
    minute = 6'd60;
    idle_mode = 1'b1;
    run_mode = 1'b0;
    exp_seg = '{7'b1111000, 7'b0110000, 7'b0111111, 7'b0111111, 7'b1111000, 7'b1111111};
    for (int i = 0; i < 6; i++) begin
      wait_frame();
      repeat (12 * i + 6) @(negedge clk);
      exp_an = ~(8'h01 << i);
      total++;
      if (an !== exp_an || seg !== exp_seg[i] || dp !== 1'b1) begin
        bad++;
        $display("FAIL dash_idx%0d: an=%h seg=%b dp=%b, need %h %b 1", i, an, seg, dp,
                 exp_an, exp_seg[i]);
      end
    end
    hour = 5'd12;
    minute = 6'd5;
    idle_mode = 1'b0;
    run_mode = 1'b1;
  endtask

  task automatic test_tear_free();
    wait_frame();
    second = 6'd38;
    repeat (6) @(negedge clk);
    total++;
    if (seg !== 7'b1111000) begin
      bad++;
      $display("FAIL tear_idx0: seg=%b, need 1111000", seg);
    end
    repeat (12) @(negedge clk);
    total++;
    if (seg !== 7'b0110000) begin
      bad++;
      $display("FAIL tear_idx1: seg=%b, need 0110000", seg);
    end
    wait_frame();
    repeat (6) @(negedge clk);
    total++;
    if (seg !== 7'b0000000) begin
      bad++;
      $display("FAIL tear_next: seg=%b, need 0000000", seg);
    end
    // Change during idx3; it must only appear after the next snapshot
    repeat (36) @(negedge clk);
    second = 6'd37;
    repeat (24) @(negedge clk);
    total++;
    if (seg !== 7'b1111001 || an !== 8'hDF) begin
      bad++;
      $display("FAIL tear_mid_idx5: seg=%b an=%h, need 1111001 DF", seg, an);
    end
    wait_frame();
    repeat (6) @(negedge clk);
    total++;
    if (seg !== 7'b1111000) begin
      bad++;
      $display("FAIL tear_restore: seg=%b, need 1111000", seg);
    end
  endtask

  task automatic test_blink();
    wait_frame();
    edit_mode = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      if (k == 40) begin
        total++;
        if (seg !== 7'b1000000) begin
          bad++;
          $display("FAIL blink_pre: seg=%b, need 1000000", seg);
        end
      end else if (k == 100) begin
        total++;
        if (seg !== 7'h7F || dp !== 1'b0 || an !== 8'hFB) begin
          bad++;
          $display("FAIL blink_off1: seg=%b dp=%b an=%h, need 1111111 0 FB", seg, dp, an);
        end
      end else if (k == 130) begin
        total++;
        if (seg !== 7'b0100100) begin
          bad++;
          $display("FAIL blink_on1: seg=%b, need 0100100", seg);
        end
      end else if (k == 190 || k == 200) begin
        total++;
        if (seg !== 7'h7F) begin
          bad++;
          $display("FAIL blink_off2_k%0d: seg=%b, need 1111111", k, seg);
        end
      end else if (k == 250) begin
        total++;
        if (seg !== 7'b0010010 || dp !== 1'b0) begin
          bad++;
          $display("FAIL blink_on2: seg=%b dp=%b, need 0010010 0", seg, dp);
        end
      end
    end
    edit_mode = 1'b0;
    wait_frame();
  endtask

  task automatic test_reset_mid();
    int n;
    wait_frame();
    repeat (42) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: an=%h seg=%b dp=%b fs=%b, need FF 1111111 1 0", an, seg, dp, frame_start);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (an !== 8'hFF || seg !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_resume0: an=%h seg=%b, need FF 1000000", an, seg);
    end
    @(negedge clk);
    total++;
    if (an !== 8'hFE) begin
      bad++;
      $display("FAIL reset_resume1: an=%h, need FE", an);
    end
    n = 2;
    while (frame_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n != 72) begin
      bad++;
      $display("FAIL frame_period: first frame_start after %0d cycles, need 72", n);
    end
    @(negedge clk);
    total++;
    if (frame_start !== 1'b0) begin
      bad++;
      $display("FAIL frame_pulse: frame_start=%b, need 0", frame_start);
    end
  endtask

  initial begin
    test_reset();
    test_digit_content();
    test_dash_blank();
    test_tear_free();
    test_blink();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
